// File: rtl/falco_lat_mem_if.sv
// Request/response bundle between a load/store unit (master) and the
// latency-configurable data memory (slave).
//
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid && ready are both high. The source holds valid and its payload
// stable until that edge; ready may go high or low at any time and never
// depends combinationally on valid. store_ack/store_err form an unhandshaked
// one-cycle status pulse.
interface falco_lat_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BYTES = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [BYTES-1:0]      req_be;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    logic                  store_ack;
    logic                  store_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, store_ack, store_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, store_ack, store_err
    );
endinterface

// File: rtl/falco_lat_mem.sv
// Word-array data memory with configurable load latency, bounded outstanding
// loads and periodic request backpressure. Loads capture data at acceptance,
// travel through a fixed-length shift pipeline and then wait in an in-order
// response FIFO. Stores write at acceptance and answer with a status pulse.
module falco_lat_mem #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH_WORDS     = 1024,
    parameter int LOAD_LATENCY    = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STALL_PERIOD    = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    falco_lat_mem_if.slave                       bus,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SC_W  = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT = (ADDR_WIDTH+1)'(DEPTH_WORDS * BYTES);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK   = ADDR_WIDTH'(BYTES - 1);
    localparam logic [CNT_W-1:0]      MAX_CNT    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0]      PTR_LAST   = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [SC_W-1:0]       SC_LAST    = SC_W'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);

    // Storage: never reset, so stores survive a mid-run reset.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    // Request decode
    logic                  req_ready_int;
    logic                  req_fire;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  req_err;
    logic [IDX_W-1:0]      word_idx;
    logic                  load_fire;
    logic                  store_fire;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  mem_wr_en;
    logic [DATA_WIDTH-1:0] mem_wr_data;

    // Control registers
    logic             ready_en_q, ready_en_d;
    logic [SC_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic             stall_slot;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic             store_ack_q, store_ack_d;
    logic             store_err_q, store_err_d;

    // Load latency pipeline
    logic [LOAD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [LOAD_LATENCY-1:0] pipe_err_q, pipe_err_d;
    logic [DATA_WIDTH-1:0]   pipe_data_q [LOAD_LATENCY];
    logic [DATA_WIDTH-1:0]   pipe_data_d [LOAD_LATENCY];

    // Response FIFO
    logic [DATA_WIDTH-1:0]      fifo_data_q [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] fifo_err_q;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           fifo_cnt_q, fifo_cnt_d;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       resp_valid_int;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Decode the offered request: error checks, word lookup and byte-lane merge.
    always_comb begin
        req_fire     = bus.req_valid && req_ready_int;
        misaligned   = |(bus.req_addr & OFF_MASK);
        out_of_range = {1'b0, bus.req_addr} >= ADDR_LIMIT;
        req_err      = misaligned || out_of_range;
        word_idx     = IDX_W'(bus.req_addr >> OFF_W);
        load_fire    = req_fire && !bus.req_we;
        store_fire   = req_fire && bus.req_we;
        rd_word      = mem_q[word_idx];
        load_data    = req_err ? '0 : rd_word;
        mem_wr_en    = store_fire && !req_err;
        mem_wr_data  = rd_word;
        for (int b = 0; b < BYTES; b++) begin
            if (bus.req_be[b]) begin
                mem_wr_data[8*b +: 8] = bus.req_wdata[8*b +: 8];
            end
        end
    end

    // Backpressure: free-running stall slot counter and acceptance gate.
    always_comb begin
        stall_cnt_d = '0;
        stall_slot  = 1'b0;
        if (STALL_PERIOD > 0) begin
            stall_slot  = (stall_cnt_q == SC_LAST);
            stall_cnt_d = stall_slot ? '0 : stall_cnt_q + 1'b1;
        end
        ready_en_d    = 1'b1;
        req_ready_int = ready_en_q && !stall_slot && (outstanding_q < MAX_CNT);
        store_ack_d   = store_fire;
        store_err_d   = store_fire && req_err;
    end

    // Shift accepted loads toward the FIFO, one stage per cycle, never stalling.
    always_comb begin
        pipe_vld_d     = pipe_vld_q;
        pipe_err_d     = pipe_err_q;
        pipe_data_d    = pipe_data_q;
        pipe_vld_d[0]  = load_fire;
        pipe_err_d[0]  = load_fire && req_err;
        pipe_data_d[0] = load_data;
        for (int i = LOAD_LATENCY - 1; i > 0; i--) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_err_d[i]  = pipe_err_q[i-1];
            pipe_data_d[i] = pipe_data_q[i-1];
        end
    end

    // FIFO pointers, occupancy and outstanding-load accounting.
    always_comb begin
        fifo_push      = pipe_vld_q[LOAD_LATENCY-1];
        resp_valid_int = (fifo_cnt_q != '0);
        fifo_pop       = resp_valid_int && bus.resp_ready;
        wr_ptr_d       = fifo_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d       = fifo_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_cnt_d     = fifo_cnt_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        outstanding_d  = outstanding_q + CNT_W'(load_fire) - CNT_W'(fifo_pop);
    end

    // Control state with asynchronous reset; in-flight loads are flushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_q    <= 1'b0;
            stall_cnt_q   <= '0;
            outstanding_q <= '0;
            store_ack_q   <= 1'b0;
            store_err_q   <= 1'b0;
            pipe_vld_q    <= '0;
            pipe_err_q    <= '0;
            for (int i = 0; i < LOAD_LATENCY; i++) begin
                pipe_data_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            ready_en_q    <= ready_en_d;
            stall_cnt_q   <= stall_cnt_d;
            outstanding_q <= outstanding_d;
            store_ack_q   <= store_ack_d;
            store_err_q   <= store_err_d;
            pipe_vld_q    <= pipe_vld_d;
            pipe_err_q    <= pipe_err_d;
            pipe_data_q   <= pipe_data_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    // Array write for accepted, error-free stores (merged lanes precomputed).
    always_ff @(posedge clk) begin
        if (mem_wr_en) begin
            mem_q[word_idx] <= mem_wr_data;
        end
    end

    // FIFO payload storage; contents are only visible while the entry is valid.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_data_q[wr_ptr_q] <= pipe_data_q[LOAD_LATENCY-1];
            fifo_err_q[wr_ptr_q]  <= pipe_err_q[LOAD_LATENCY-1];
        end
    end

    assign bus.req_ready  = req_ready_int;
    assign bus.resp_valid = resp_valid_int;
    assign bus.resp_rdata = resp_valid_int ? fifo_data_q[rd_ptr_q] : '0;
    assign bus.resp_err   = resp_valid_int ? fifo_err_q[rd_ptr_q] : 1'b0;
    assign bus.store_ack  = store_ack_q;
    assign bus.store_err  = store_err_q;
    assign outstanding    = outstanding_q;

endmodule

// File: tb/tb_falco_lat_mem.sv
// Bench for falco_lat_mem: a main instance (latency 3, 4 outstanding, no
// stalls) checked every cycle against a queue-based model, plus a second
// instance with STALL_PERIOD=4 for the backpressure pattern.
module tb_falco_lat_mem;
  localparam int L = 3;
  localparam int M = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] outstanding;
  logic [2:0] outstanding_s;

  // ---------------- clock / reset / DUTs ----------------
  always #5 clk = ~clk;

  falco_lat_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  falco_lat_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_s ();

  falco_lat_mem #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024),
    .LOAD_LATENCY(L), .MAX_OUTSTANDING(M), .STALL_PERIOD(0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .outstanding(outstanding)
  );

  falco_lat_mem #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024),
    .LOAD_LATENCY(2), .MAX_OUTSTANDING(4), .STALL_PERIOD(4)
  ) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s), .outstanding(outstanding_s)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // exp_q entry: {accept edge number[15:0], err, data[31:0]}
  logic [31:0] mdl_mem [1024];
  logic [48:0] exp_q[$];
  int edge_n = 0;
  logic ready_en = 1'b0;
  logic exp_ack = 1'b0;
  logic exp_ack_err = 1'b0;

  initial for (int i = 0; i < 1024; i++) mdl_mem[i] = '0;

  function automatic logic m_ready();
    return ready_en && (exp_q.size() < M);
  endfunction

  function automatic logic m_rvalid();
    return (exp_q.size() > 0) && (edge_n >= int'(exp_q[0][48:33]) + L);
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic hs_req, hs_resp, err;
    int idx;
    logic [31:0] d;
    if (rst) begin
      exp_q.delete();
      ready_en = 1'b0;
      exp_ack = 1'b0;
      exp_ack_err = 1'b0;
    end else begin
      hs_req = bus.req_valid && m_ready();
      hs_resp = m_rvalid() && bus.resp_ready;
      edge_n++;
      ready_en = 1'b1;
      if (hs_resp) void'(exp_q.pop_front());
      exp_ack = hs_req && bus.req_we;
      exp_ack_err = 1'b0;
      if (hs_req) begin
        err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr >= 32'd4096);
        idx = int'(bus.req_addr[11:2]);
        if (bus.req_we) begin
          exp_ack_err = err;
          if (!err) begin
            for (int b = 0; b < 4; b++) begin
              if (bus.req_be[b]) mdl_mem[idx][8*b +: 8] = bus.req_wdata[8*b +: 8];
            end
          end
        end else begin
          d = err ? 32'h0 : mdl_mem[idx];
          exp_q.push_back({16'(edge_n), err, d});
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_resp_rdata", bus.resp_rdata, 0);
      chk("rst_resp_err", bus.resp_err, 0);
      chk("rst_store_ack", bus.store_ack, 0);
      chk("rst_store_err", bus.store_err, 0);
      chk("rst_outstanding", outstanding, 0);
    end else begin
      chk("req_ready", bus.req_ready, m_ready());
      chk("resp_valid", bus.resp_valid, m_rvalid());
      if (m_rvalid()) begin
        chk("resp_rdata", bus.resp_rdata, exp_q[0][31:0]);
        chk("resp_err", bus.resp_err, exp_q[0][32]);
      end
      chk("store_ack", bus.store_ack, exp_ack);
      chk("store_err", bus.store_err, exp_ack_err);
      chk("outstanding", outstanding, exp_q.size());
    end
  end

  // Record every response handshake in order: {err, data}.
  logic [32:0] rx_q[$];
  always @(posedge clk) begin
    if (!rst && bus.resp_valid && bus.resp_ready) rx_q.push_back({bus.resp_err, bus.resp_rdata});
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be);
    int budget;
    logic rdy;
    budget = 0;
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    bus.req_be = be;
    do begin
      rdy = bus.req_ready;
      tick();
      budget++;
    end while (!rdy && budget < 200);
    chk("req_accept_timeout", rdy, 1);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (outstanding != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_timeout", outstanding == 0, 1);
  endtask

  function automatic logic [32:0] rx_at(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 33'h1_dead_dead;
  endfunction

  // ---------------- directed stimulus ----------------
  initial begin
    int acc;
    int n;
    int base;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_be = '0;
    bus.resp_ready = 1'b1;
    bus_s.req_valid = 1'b1;
    bus_s.req_we = 1'b0;
    bus_s.req_addr = '0;
    bus_s.req_wdata = '0;
    bus_s.req_be = '0;
    bus_s.resp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("lit_rst_ready", bus.req_ready, 0);
    chk("lit_rst_outstanding", outstanding, 0);
    rst = 1'b0;

    // Stall injector: ready low on every 4th cycle, 3 accepts per 4 cycles.
    acc = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("stall_ready", bus_s.req_ready, (k % 4) != 3);
      if (bus_s.req_ready) acc++;
    end
    chk("lit_stall_accepts", acc, 9);
    bus_s.req_valid = 1'b0;
    chk("lit_ready_after_rst", bus.req_ready, 1);

    // Store then load, latency 3.
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    chk("lit_store_ack", bus.store_ack, 1);
    chk("lit_store_err", bus.store_err, 0);
    send(1'b0, 32'h10, 32'h0, 4'h0);
    chk("lit_out_one", outstanding, 1);
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("lit_load_latency", n, 3);
    chk("lit_rdata_beef", bus.resp_rdata, 32'hDEADBEEF);
    tick();
    chk("lit_out_zero", outstanding, 0);

    // Partial store.
    send(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF);
    send(1'b1, 32'h20, 32'h11223344, 4'b0101);
    send(1'b0, 32'h20, 32'h0, 4'h0);
    wait_idle();
    chk("lit_partial", rx_at(rx_q.size() - 1), {1'b0, 32'hFF22FF44});

    // Error cases.
    base = rx_q.size();
    send(1'b0, 32'h3, 32'h0, 4'h0);
    send(1'b0, 32'h1000, 32'h0, 4'h0);
    send(1'b1, 32'h1002, 32'h12345678, 4'hF);
    chk("lit_oor_store_ack", bus.store_ack, 1);
    chk("lit_oor_store_err", bus.store_err, 1);
    send(1'b1, 32'h22, 32'h00000000, 4'hF);
    chk("lit_mis_store_err", bus.store_err, 1);
    send(1'b0, 32'h20, 32'h0, 4'h0);
    wait_idle();
    chk("lit_err_mis_load", rx_at(base), {1'b1, 32'h0});
    chk("lit_err_oor_load", rx_at(base + 1), {1'b1, 32'h0});
    chk("lit_err_unchanged", rx_at(base + 2), {1'b0, 32'hFF22FF44});

    // Outstanding limit with responses held off.
    for (int i = 0; i < 6; i++) send(1'b1, 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
    bus.resp_ready = 1'b0;
    base = rx_q.size();
    fork
      begin
        for (int i = 0; i < 6; i++) send(1'b0, 32'(4 * i), 32'h0, 4'h0);
      end
      begin
        repeat (8) tick();
        chk("lit_full_outstanding", outstanding, 4);
        chk("lit_full_ready", bus.req_ready, 0);
        bus.resp_ready = 1'b1;
      end
    join
    wait_idle();
    for (int i = 0; i < 6; i++) chk("lit_order", rx_at(base + i), {1'b0, 32'hA0 + 32'(i)});

    // Reset with loads in flight.
    bus.resp_ready = 1'b0;
    base = rx_q.size();
    send(1'b0, 32'h20, 32'h0, 4'h0);
    send(1'b0, 32'h20, 32'h0, 4'h0);
    send(1'b0, 32'h20, 32'h0, 4'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("lit_flush_valid", bus.resp_valid, 0);
    chk("lit_flush_outstanding", outstanding, 0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    repeat (8) tick();
    chk("lit_no_stale", rx_q.size(), base);
    send(1'b0, 32'h20, 32'h0, 4'h0);
    wait_idle();
    chk("lit_persist", rx_at(rx_q.size() - 1), {1'b0, 32'hFF22FF44});

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
